// File: rtl/decode_pkg.sv
// decode_pkg: shared types and helpers for the decode stage.
// Holds the op encoding, DP funct codes, special register numbers, the
// decoded output record and the pure field/read-set decode functions.
package decode_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  localparam logic [3:0] F_AND = 4'h0;
  localparam logic [3:0] F_EOR = 4'h1;
  localparam logic [3:0] F_SUB = 4'h2;
  localparam logic [3:0] F_RSB = 4'h3;
  localparam logic [3:0] F_ADD = 4'h4;
  localparam logic [3:0] F_ADC = 4'h5;
  localparam logic [3:0] F_SBC = 4'h6;
  localparam logic [3:0] F_RSC = 4'h7;
  localparam logic [3:0] F_TST = 4'h8;
  localparam logic [3:0] F_TEQ = 4'h9;
  localparam logic [3:0] F_CMP = 4'hA;
  localparam logic [3:0] F_CMN = 4'hB;
  localparam logic [3:0] F_ORR = 4'hC;
  localparam logic [3:0] F_MOV = 4'hD;
  localparam logic [3:0] F_BIC = 4'hE;
  localparam logic [3:0] F_MVN = 4'hF;

  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [3:0]  cond;
    logic        useMemory;
    logic        memWrite;
    logic        regWrite;
    logic        branch;
    logic        link;
    logic        immSel;
    logic        setFlags;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  funct;
    logic [23:0] imm;
  } decoded_t;

  // Which register fields the instruction actually reads.
  typedef struct packed {
    logic rn;
    logic rm;
    logic rd;
  } reads_t;

  // Raw fields are always extracted; only the controls depend on op.
  function automatic decoded_t decode_fields(input logic [31:0] instr);
    decoded_t d;
    op_e      op;
    logic     is_test;
    d       = '0;
    op      = op_e'(instr[27:26]);
    is_test = (instr[24:21] == F_TST) || (instr[24:21] == F_TEQ) ||
              (instr[24:21] == F_CMP) || (instr[24:21] == F_CMN);
    d.cond  = instr[31:28];
    d.rd    = instr[15:12];
    d.rn    = instr[19:16];
    d.rm    = instr[3:0];
    d.funct = instr[24:21];
    d.imm   = instr[23:0];
    case (op)
      OP_DP: begin
        d.immSel   = instr[25];
        d.setFlags = instr[20];
        d.regWrite = ~is_test;
      end
      OP_MEM: begin
        d.useMemory = 1'b1;
        d.memWrite  = ~instr[20];
        d.regWrite  = instr[20];
        d.immSel    = ~instr[25];
      end
      OP_BR: begin
        d.branch = 1'b1;
        d.link   = instr[24];
        if (instr[24]) begin
          d.regWrite = 1'b1;
          d.rd       = REG_LR;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic reads_t decode_reads(input logic [31:0] instr);
    reads_t r;
    r = '0;
    case (op_e'(instr[27:26]))
      OP_DP: begin
        r.rn = ~((instr[24:21] == F_MOV) || (instr[24:21] == F_MVN));
        r.rm = ~instr[25];
      end
      OP_MEM: begin
        r.rn = 1'b1;
        r.rm = instr[25];
        r.rd = ~instr[20];  // store data register
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: handshake, writeback and decoded-output bundle of the decode stage.
// master = upstream/execute side driving instructions, out_ready and retires;
// slave = the decode stage itself.
interface decode_if #(parameter int WB_PORTS = 1);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instruction;
  logic                  flush;
  logic [WB_PORTS-1:0]   wb_valid;
  logic [4*WB_PORTS-1:0] wb_rd;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            cond;
  logic                  useMemory;
  logic                  memWrite;
  logic                  regWrite;
  logic                  branch;
  logic                  link;
  logic                  immSel;
  logic                  setFlags;
  logic [3:0]            rd;
  logic [3:0]            rn;
  logic [3:0]            rm;
  logic [3:0]            funct;
  logic [23:0]           imm;
  logic                  sb_err;

  modport master (
    output in_valid, instruction, flush, wb_valid, wb_rd, out_ready,
    input  in_ready, out_valid, cond, useMemory, memWrite, regWrite, branch,
           link, immSel, setFlags, rd, rn, rm, funct, imm, sb_err
  );

  modport slave (
    input  in_valid, instruction, flush, wb_valid, wb_rd, out_ready,
    output in_ready, out_valid, cond, useMemory, memWrite, regWrite, branch,
           link, immSel, setFlags, rd, rn, rm, funct, imm, sb_err
  );
endinterface

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: per-register counters of in-flight writes.
// Ports: inc_vld_i/inc_rd_i (issue), wb_valid_i/wb_rd_i (retires),
// q_*_i -> q_*_cnt_o (three combinational count lookups), sb_err_o (sticky).
module decode_scoreboard #(
  parameter int CNT_W    = 2,
  parameter int WB_PORTS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_vld_i,
  input  logic [3:0]            inc_rd_i,
  input  logic [WB_PORTS-1:0]   wb_valid_i,
  input  logic [4*WB_PORTS-1:0] wb_rd_i,
  input  logic [3:0]            q_rn_i,
  input  logic [3:0]            q_rm_i,
  input  logic [3:0]            q_rd_i,
  output logic [CNT_W-1:0]      q_rn_cnt_o,
  output logic [CNT_W-1:0]      q_rm_cnt_o,
  output logic [CNT_W-1:0]      q_rd_cnt_o,
  output logic                  sb_err_o
);
  // Wide enough for count+1 and for WB_PORTS simultaneous retires.
  localparam int SUM_W = CNT_W + $clog2(WB_PORTS + 1) + 1;

  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];
  logic [15:0]      under;
  logic             sb_err_q;

  for (genvar r = 0; r < 16; r++) begin : g_cnt
    if (r == 15) begin : g_pc
      // PC is never tracked; its retires are ignored.
      assign cnt_d[r] = '0;
      assign under[r] = 1'b0;
    end else begin : g_reg
      logic [SUM_W-1:0] dec;
      logic [SUM_W-1:0] avail;
      always_comb begin
        dec = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_valid_i[p] && (wb_rd_i[4*p +: 4] == 4'(r))) dec = dec + SUM_W'(1);
        end
        avail = SUM_W'(cnt_q[r]) + SUM_W'(inc_vld_i && (inc_rd_i == 4'(r)));
      end
      // Net-sum of same-cycle issue and retires; clamp at zero on underflow.
      assign under[r] = (dec > avail);
      assign cnt_d[r] = under[r] ? '0 : CNT_W'(avail - dec);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= cnt_d[r];
      if (|under) sb_err_q <= 1'b1;
    end
  end

  assign q_rn_cnt_o = cnt_q[q_rn_i];
  assign q_rm_cnt_o = cnt_q[q_rm_i];
  assign q_rd_cnt_o = cnt_q[q_rd_i];
  assign sb_err_o   = sb_err_q;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with RAW/WAW hazard stalls.
// Latency 1 cycle accept->out_valid, 1/cycle throughput; input stalls on
// flush, hazard, or held slot not drained. Ports: clk, rst, bus (decode_if.slave).
module decode_stage
  import decode_pkg::*;
#(
  parameter int CNT_W    = 2,
  parameter int WB_PORTS = 1
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);
  localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'((1 << CNT_W) - 1);

  decoded_t         slot_d, slot_q;
  reads_t           rs;
  logic             out_valid_q;
  logic             slot_wr;
  logic             haz_rn, haz_rm, haz_rd, haz_waw, hazard;
  logic             in_ready;
  logic             issue;
  logic [CNT_W-1:0] rn_cnt, rm_cnt, rd_cnt;

  assign slot_d = decode_fields(bus.instruction);
  assign rs     = decode_reads(bus.instruction);

  // The held slot's write is not yet in the counters (it is counted at the
  // output handshake), so it is checked separately.
  assign slot_wr = out_valid_q && slot_q.regWrite && (slot_q.rd != REG_PC);

  assign haz_rn = rs.rn && (slot_d.rn != REG_PC) &&
                  ((rn_cnt != '0) || (slot_wr && (slot_q.rd == slot_d.rn)));
  assign haz_rm = rs.rm && (slot_d.rm != REG_PC) &&
                  ((rm_cnt != '0) || (slot_wr && (slot_q.rd == slot_d.rm)));
  assign haz_rd = rs.rd && (slot_d.rd != REG_PC) &&
                  ((rd_cnt != '0) || (slot_wr && (slot_q.rd == slot_d.rd)));
  assign haz_waw = slot_d.regWrite && (slot_d.rd != REG_PC) &&
                   ((CNT_W+1)'(rd_cnt) + (CNT_W+1)'(slot_wr && (slot_q.rd == slot_d.rd)) >= CNT_MAX);
  assign hazard = haz_rn || haz_rm || haz_rd || haz_waw;

  assign in_ready = ~bus.flush & ~hazard & (~out_valid_q | bus.out_ready);

  // Counted even when flushed in the same cycle: execute already took it.
  assign issue = out_valid_q && bus.out_ready && slot_q.regWrite;

  decode_scoreboard #(.CNT_W(CNT_W), .WB_PORTS(WB_PORTS)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .inc_vld_i  (issue),
    .inc_rd_i   (slot_q.rd),
    .wb_valid_i (bus.wb_valid),
    .wb_rd_i    (bus.wb_rd),
    .q_rn_i     (slot_d.rn),
    .q_rm_i     (slot_d.rm),
    .q_rd_i     (slot_d.rd),
    .q_rn_cnt_o (rn_cnt),
    .q_rm_cnt_o (rm_cnt),
    .q_rd_cnt_o (rd_cnt),
    .sb_err_o   (bus.sb_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      slot_q      <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (bus.in_valid && in_ready) begin
      out_valid_q <= 1'b1;
      slot_q      <= slot_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.cond      = slot_q.cond;
  assign bus.useMemory = slot_q.useMemory;
  assign bus.memWrite  = slot_q.memWrite;
  assign bus.regWrite  = slot_q.regWrite;
  assign bus.branch    = slot_q.branch;
  assign bus.link      = slot_q.link;
  assign bus.immSel    = slot_q.immSel;
  assign bus.setFlags  = slot_q.setFlags;
  assign bus.rd        = slot_q.rd;
  assign bus.rn        = slot_q.rn;
  assign bus.rm        = slot_q.rm;
  assign bus.funct     = slot_q.funct;
  assign bus.imm       = slot_q.imm;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage (CNT_W=2, WB_PORTS=2).
// Stimulus pushes expected decoded records; a negedge monitor pops and compares
// on every output handshake.
module tb_decode_stage;
  import decode_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  decoded_t expq[$];

  decode_if #(.WB_PORTS(2)) bus ();

  decode_stage #(.CNT_W(2), .WB_PORTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ctl = {useMemory, memWrite, regWrite, branch, link, immSel, setFlags}
  function automatic decoded_t mk(input logic [3:0] cond, input logic [6:0] ctl,
                                  input logic [3:0] rd, input logic [3:0] rn,
                                  input logic [3:0] rm, input logic [3:0] funct,
                                  input logic [23:0] imm);
    return {cond, ctl, rd, rn, rm, funct, imm};
  endfunction

  function automatic decoded_t cur_out();
    return {bus.cond, bus.useMemory, bus.memWrite, bus.regWrite, bus.branch,
            bus.link, bus.immSel, bus.setFlags, bus.rd, bus.rn, bus.rm,
            bus.funct, bus.imm};
  endfunction

  // Monitor: compare every output handshake against the next expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        chk("out_unexpected", 64'(cur_out()), 64'hDEAD);
      end else begin
        chk("out_fields", 64'(cur_out()), 64'(expq.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic retire(input logic [1:0] v, input logic [7:0] r);
    bus.wb_valid = v;
    bus.wb_rd    = r;
    @(posedge clk);
    #1;
    bus.wb_valid = '0;
    bus.wb_rd    = '0;
  endtask

  // Present ins; expect in_ready low for stall_n cycles plus the retire cycle
  // (if wbv!=0), then high in the following cycle.
  task automatic issue(input string nm, input logic [31:0] ins, input decoded_t exp,
                       input bit push, input int stall_n,
                       input logic [1:0] wbv, input logic [7:0] wbr);
    int bad;
    bad = 0;
    bus.in_valid    = 1'b1;
    bus.instruction = ins;
    for (int i = 0; i < stall_n; i++) begin
      @(negedge clk);
      if (bus.in_ready) bad++;
      @(posedge clk);
      #1;
    end
    if (wbv != 2'b00) begin
      bus.wb_valid = wbv;
      bus.wb_rd    = wbr;
      @(negedge clk);
      if (bus.in_ready) bad++;
      @(posedge clk);
      #1;
      bus.wb_valid = '0;
      bus.wb_rd    = '0;
    end
    if (stall_n > 0 || wbv != 2'b00) chk({nm, "_stall"}, 64'(bad), 64'd0);
    @(negedge clk);
    chk({nm, "_accept"}, 64'(bus.in_ready), 64'd1);
    if (push) expq.push_back(exp);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  decoded_t e_mov0, e_ldr, e_cmp, e_b0, e_b1, e_mov4, e_str4, e_bl, e_add, e_str2, e_mov5;

  initial begin
    e_mov0 = mk(4'hE, 7'b0010010, 4'h0, 4'h0, 4'h0, 4'hD, 24'ha00000);
    e_ldr  = mk(4'hE, 7'b1010010, 4'h1, 4'h0, 4'h0, 4'hC, 24'h901000);
    e_cmp  = mk(4'hE, 7'b0000011, 4'h0, 4'h1, 4'hF, 4'hA, 24'h5100ff);
    e_b0   = mk(4'h0, 7'b0001000, 4'h0, 4'h0, 4'hF, 4'h0, 24'h00003f);
    e_b1   = mk(4'hE, 7'b0001000, 4'hF, 4'hF, 4'hF, 4'h7, 24'hffffdf);
    e_mov4 = mk(4'hE, 7'b0010010, 4'h4, 4'h0, 4'h1, 4'hD, 24'ha04001);
    e_str4 = mk(4'hE, 7'b1100010, 4'h4, 4'h0, 4'h0, 4'hC, 24'h804000);
    e_bl   = mk(4'hE, 7'b0011100, 4'hE, 4'h0, 4'h0, 4'h8, 24'h000010);
    e_add  = mk(4'hE, 7'b0010010, 4'h0, 4'h2, 4'h1, 4'h4, 24'h820001);
    e_str2 = mk(4'hE, 7'b1100010, 4'h2, 4'h0, 4'h0, 4'hC, 24'h802000);
    e_mov5 = mk(4'hE, 7'b0010010, 4'h5, 4'h0, 4'h0, 4'hD, 24'ha05000);

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.instruction = '0;
    bus.flush       = 1'b0;
    bus.wb_valid    = '0;
    bus.wb_rd       = '0;
    bus.out_ready   = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_fields", 64'(cur_out()), 64'd0);
    chk("rst_sb_err", 64'(bus.sb_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // MOV r0 then LDR r1,[r0]: LDR waits for r0 retire, then goes.
    issue("mov0", 32'he3a00000, e_mov0, 1'b1, 0, 2'b00, 8'h00);
    issue("ldr",  32'he5901000, e_ldr,  1'b1, 3, 2'b01, 8'h00);
    idle(2);
    retire(2'b01, 8'h01);

    // CMP: no write, reads r1 (already retired).
    issue("cmp", 32'he35100ff, e_cmp, 1'b1, 0, 2'b00, 8'h00);

    // Branches back to back, never stalling.
    issue("b0", 32'h0a00003f, e_b0, 1'b1, 0, 2'b00, 8'h00);
    issue("b1", 32'heaffffdf, e_b1, 1'b1, 0, 2'b00, 8'h00);

    // STR r4 with r4 in flight: waits on the rd read.
    issue("mov4", 32'he3a04001, e_mov4, 1'b1, 0, 2'b00, 8'h00);
    idle(3);
    issue("str4", 32'he5804000, e_str4, 1'b1, 2, 2'b01, 8'h04);

    // BL writes LR.
    issue("bl", 32'heb000010, e_bl, 1'b1, 0, 2'b00, 8'h00);
    idle(3);
    retire(2'b01, 8'h0E);

    // Saturation: three ADD r0 fill the counter, fourth waits; a dual-port
    // retire of r0 removes two.
    issue("add_a", 32'he2820001, e_add, 1'b1, 0, 2'b00, 8'h00);
    issue("add_b", 32'he2820001, e_add, 1'b1, 0, 2'b00, 8'h00);
    issue("add_c", 32'he2820001, e_add, 1'b1, 0, 2'b00, 8'h00);
    issue("add_d", 32'he2820001, e_add, 1'b1, 3, 2'b11, 8'h00);
    idle(2);
    retire(2'b01, 8'h00);
    retire(2'b10, 8'h00);
    @(negedge clk);
    chk("sat_sb_err", 64'(bus.sb_err), 64'd0);
    @(posedge clk);
    #1;
    // r0 must be fully drained: a reader of r0 goes straight through.
    issue("str2_a", 32'he5802000, e_str2, 1'b1, 0, 2'b00, 8'h00);

    // Flush coinciding with a handshake: the write is still counted.
    issue("mov5", 32'he3a05000, e_mov5, 1'b1, 0, 2'b00, 8'h00);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_hs_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_hs_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    retire(2'b01, 8'h05);
    @(negedge clk);
    chk("flush_hs_sb_err", 64'(bus.sb_err), 64'd0);
    @(posedge clk);
    #1;

    // Flush while holding MOV r0 with execute stalled.
    bus.out_ready = 1'b0;
    issue("mov0_held", 32'he3a00000, e_mov0, 1'b0, 0, 2'b00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_fields", 64'(cur_out()), 64'(e_mov0));
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    // Flushed MOV r0 was never counted: r0 reader is not blocked.
    issue("str2_b", 32'he5802000, e_str2, 1'b1, 0, 2'b00, 8'h00);
    idle(3);

    // Retire of a register with nothing in flight.
    retire(2'b01, 8'h03);
    @(negedge clk);
    chk("sb_err_set", 64'(bus.sb_err), 64'd1);
    @(posedge clk);
    #1;

    // Drain the expectation queue (bounded).
    for (int i = 0; i < 20 && expq.size() != 0; i++) idle(1);
    chk("drain", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction-decode stage for the pipelined CPU, replacing the single-cycle combinational decoder. Accepts one 32-bit ARM-subset instruction per cycle, splits it into control and register fields, and holds them in an output register for execute. Tracks in-flight register writes in a per-register counting scoreboard, stalling RAW/WAW-saturation hazards until writeback retires them. Supports a parametrised number of writeback ports.

## Interface
- `CNT_W`, 2: width of each scoreboard counter; max outstanding writes per register = 2**CNT_W-1.
- `WB_PORTS`, 1: number of independent writeback retire ports.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage accepts instruction this cycle.
- `instruction`  in  32  raw instruction word.
- `flush`  in  1  discard held instruction, block input this cycle.
- `wb_valid`  in  WB_PORTS  per-port retire strobe.
- `wb_rd`  in  4*WB_PORTS  per-port retired register, port p at [4p+3:4p].
- `out_valid`  out  1  decoded instruction held.
- `out_ready`  in  1  execute consumes held instruction.
- `cond`  out  4  instruction[31:28].
- `useMemory`, `memWrite`, `regWrite`, `branch`, `link`, `immSel`, `setFlags`  out  1 each  control.
- `rd`, `rn`, `rm`, `funct`  out  4 each  fields.
- `imm`  out  24  instruction[23:0].
- `sb_err`  out  1  sticky: retire seen for register with zero count.

## Operation
- op = instruction[27:26]: 00 DP, 01 MEM, 10 BR; 11 decodes as NOP (all controls 0).
- DP: funct=[24:21], immSel=[25], setFlags=[20], regWrite=1 unless funct∈{1000,1001,1010,1011}; rn read unless funct∈{1101,1111}; rm read iff immSel=0.
- MEM: useMemory=1, memWrite=~[20], regWrite=[20], immSel=~[25]; reads rn; reads rm iff [25]=1; STR also reads rd.
- BR: branch=1, link=[24]; link sets regWrite=1, rd=14; reads nothing.
- Register 15 never counted, never causes a stall.
- Hazard (input not accepted) if any read register r has cnt[r]≠0 or matches the held slot's regWrite rd; or if regWrite and cnt[rd]+(held slot writes rd) ≥ 2**CNT_W-1.
- in_ready = ~flush & ~hazard & (~out_valid | out_ready).
- Scoreboard increments cnt[rd] on output handshake (out_valid & out_ready & regWrite & rd≠15); decrements once per asserted wb port matching. Same-cycle inc/dec net-sum. Two ports same register decrement by 2.
- Retire with insufficient count: counter clamps at 0, sb_err set, cleared only by reset.
- Execute contract: wb_valid pulses for every issued regWrite instruction, including condition-failed ones.
- flush: out_valid→0 next cycle, scoreboard untouched; instructions already issued downstream still retire.

## Timing
- Reset: out_valid=0, every field/control 0, all counters 0, sb_err=0; reset mid-transfer drops held instruction.
- Latency 1 cycle accept→out_valid; full throughput 1/cycle with out_ready=1 and no hazards.
- Held outputs stable while out_valid & ~out_ready.
- Retire at cycle t unblocks dependent input at cycle t+1 (counter registered, no bypass).
- flush with out_ready same cycle: handshake counted, slot cleared.

## Structure
- `decode_pkg`: op enum (OP_DP, OP_MEM, OP_BR), funct constants (AND..MVN, CMP/CMN/TST/TEQ), `decoded_t` struct of all output fields, REG_LR=14, REG_PC=15.
- Sub-module `decode_scoreboard`: counters, inc/dec, pending lookup, sb_err.
- Top: combinational field decode + output register + handshake.

## Test plan
- e3a00000 then e5901000, out_ready=1, no wb → MOV out (regWrite, rd=0, immSel); LDR stalled until wb_rd=0 pulse, then out next cycle (useMemory, rd=1, rn=0).
- e35100ff → regWrite=0, setFlags=1, funct=1010, imm=0x5100ff; no counter change.
- 0a00003f, eaffffdf → branch=1, cond=0 then E, imm=0x00003f / 0xffffdf, never stalls.
- e5804000 with cnt[4]=1 → stalls on rd read; wb_rd=4 releases; memWrite=1.
- CNT_W=2: three ADD r0 writes issued, fourth stalls; WB_PORTS=2 retiring r0 on both ports → cnt drops by 2.
- flush while holding MOV r0 → out_valid 0, cnt[0] unchanged; wb for empty register → sb_err=1.
